hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage pipeline. It detects load-use hazards in ID and stalls PC and IF/ID while inserting bubbles into ID/EX for a programmable number of cycles. It flushes the wrong-path stages when a taken branch resolves in MEM, and generates EX-stage forwarding selects from the EX/MEM and MEM/WB buffer contents. It consumes the outputs of the four pipeline buffers and drives their write-enable and flush inputs.

---
 rtl/hazard_if.sv | 46 ++++
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard unit bundle: pipeline-buffer fields in, stall/flush/forward controls out.
// Master is the pipeline side, slave is the hazard unit.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic             mem_branch;
  logic             mem_zero;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read,
    output ex_rs, ex_rt, mem_reg_write, mem_rd,
    output mem_branch, mem_zero, wb_reg_write, wb_rd,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read,
    input  ex_rs, ex_rt, mem_reg_write, mem_rd,
    input  mem_branch, mem_zero, wb_reg_write, wb_rd,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: load-use stalls,
// taken-branch flushes and EX-stage forwarding selects.
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input logic   clk,
  input logic   rst,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic br_taken, load_use;
  logic pc_we, ifid_we, ifid_fl, idex_fl, exmem_fl;
  logic [1:0] fwd_a, fwd_b;

  assign br_taken = hz.mem_branch & hz.mem_zero;
  assign load_use = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
                    ((hz.ex_rt == hz.id_rs) |
                     (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else if (br_taken) begin
      // Wrong-path squash outranks any stall in flight
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
      state_d  = FLUSH;
      cnt_d    = 4'd0;
    end else begin
      unique case (state_q)
        STALL: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_fl = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
        FLUSH: state_d = RUN;
        default: begin
          if (load_use) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_d   = CNT_INIT;
              state_d = STALL;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.mem_reg_write && hz.mem_rd != 5'd0 &&
          hz.mem_rd == hz.ex_rs)
        fwd_a = 2'b10;
      else if (hz.wb_reg_write && hz.wb_rd != 5'd0 &&
               hz.wb_rd == hz.ex_rs)
        fwd_a = 2'b01;
      if (hz.mem_reg_write && hz.mem_rd != 5'd0 &&
          hz.mem_rd == hz.ex_rt)
        fwd_b = 2'b10;
      else if (hz.wb_reg_write && hz.wb_rd != 5'd0 &&
               hz.wb_rd == hz.ex_rt)
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_we && stall_q != '1) stall_d = stall_q + 1'b1;
    if (!rst && br_taken && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.pc_write     = pc_we;
  assign hz.if_id_write  = ifid_we;
  assign hz.if_id_flush  = ifid_fl;
  assign hz.id_ex_flush  = idex_fl;
  assign hz.ex_mem_flush = exmem_fl;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.state        = state_q;
  assign hz.stall_count  = stall_q;
  assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three configurations share one stimulus
// stream; each expected record names the instance it applies to.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic id_uses_rt, ex_mem_read, mem_reg_write;
  logic mem_branch, mem_zero, wb_reg_write;

  hazard_if #(.CNT_W(16)) h0 ();
  hazard_if #(.CNT_W(16)) h1 ();
  hazard_if #(.CNT_W(4))  h2 ();

`define DRV(h) \
  assign h.id_rs = id_rs; \
  assign h.id_rt = id_rt; \
  assign h.id_uses_rt = id_uses_rt; \
  assign h.ex_mem_read = ex_mem_read; \
  assign h.ex_rs = ex_rs; \
  assign h.ex_rt = ex_rt; \
  assign h.mem_reg_write = mem_reg_write; \
  assign h.mem_rd = mem_rd; \
  assign h.mem_branch = mem_branch; \
  assign h.mem_zero = mem_zero; \
  assign h.wb_reg_write = wb_reg_write; \
  assign h.wb_rd = wb_rd;

  `DRV(h0)
  `DRV(h1)
  `DRV(h2)

  hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .hz(h0.slave));
  hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .hz(h1.slave));
  hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .hz(h2.slave));

`define OBS(h) {h.pc_write, h.if_id_write, h.if_id_flush, \
  h.id_ex_flush, h.ex_mem_flush, h.fwd_a, h.fwd_b, h.state, \
  16'(h.stall_count), 16'(h.flush_count)}

  logic [42:0] obs [3];
  always_comb begin
    obs[0] = `OBS(h0);
    obs[1] = `OBS(h1);
    obs[2] = `OBS(h2);
  end

  typedef struct {
    int          sel;
    string       name;
    logic [42:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic push(input int sel, input string nm,
                      input logic [4:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [1:0] st,
                      input int sc, input int fc);
    exp_t e;
    e.sel  = sel;
    e.name = nm;
    e.exp  = {ctl, fa, fb, st, 16'(sc), 16'(fc)};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [42:0] g;
      e = q.pop_front();
      g = obs[e.sel];
      n_vec++;
      if (g !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b fa=%b fb=%b st=%b sc=%0d fc=%0d, exp ctl=%b fa=%b fb=%b st=%b sc=%0d fc=%0d",
                 e.name, g[42:38], g[37:36], g[35:34], g[33:32],
                 g[31:16], g[15:0], e.exp[42:38], e.exp[37:36],
                 e.exp[35:34], e.exp[33:32], e.exp[31:16],
                 e.exp[15:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rs = 0; ex_rt = 0;
    mem_reg_write = 0; mem_rd = 0;
    mem_branch = 0; mem_zero = 0;
    wb_reg_write = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clr();
    cyc();
    rst = 1'b0;
  endtask

  task automatic lw_hazard();
    clr();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
  endtask

  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] FL3 = 5'b11111;

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    // hazard present while reset is held: outputs forced to defaults
    lw_hazard();
    mem_reg_write = 1; mem_rd = 3; ex_rs = 3;
    push(0, "rst_defaults", DEF, 2'b00, 2'b00, 2'b00, 0, 0);
    push(1, "rst_defaults1", DEF, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc();
    rst = 1'b0;
    clr();

    // single-cycle load-use stall
    cyc(); lw_hazard();
    push(0, "lu1_stall", STL, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); clr();
    push(0, "lu1_after", DEF, 2'b00, 2'b00, 2'b00, 1, 0);

    // three-cycle stall continues after ex_mem_read drops
    do_reset();
    cyc(); lw_hazard();
    push(1, "lu3_c0", STL, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); clr();
    push(1, "lu3_c1", STL, 2'b00, 2'b00, 2'b01, 1, 0);
    cyc();
    push(1, "lu3_c2", STL, 2'b00, 2'b00, 2'b01, 2, 0);
    cyc();
    push(1, "lu3_done", DEF, 2'b00, 2'b00, 2'b00, 3, 0);

    // $0 never stalls; rt compare gated by id_uses_rt
    do_reset();
    cyc(); clr(); ex_mem_read = 1;
    push(0, "lu_r0", DEF, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); clr();
    ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_rs = 1;
    push(0, "lu_rt_unused", DEF, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); id_uses_rt = 1;
    push(0, "lu_rt_used", STL, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); clr();
    push(0, "lu_rt_after", DEF, 2'b00, 2'b00, 2'b00, 1, 0);

    // taken branch aborts a stall; FLUSH masks load-use
    do_reset();
    cyc(); lw_hazard();
    push(1, "br_c0", STL, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); clr(); mem_branch = 1; mem_zero = 1;
    push(1, "br_taken", FL3, 2'b00, 2'b00, 2'b01, 1, 0);
    cyc(); lw_hazard();
    push(1, "br_flush_st", DEF, 2'b00, 2'b00, 2'b10, 1, 1);
    cyc(); clr();
    push(1, "br_run", DEF, 2'b00, 2'b00, 2'b00, 1, 1);
    cyc(); mem_branch = 1;
    push(1, "br_not_taken", DEF, 2'b00, 2'b00, 2'b00, 1, 1);
    cyc(); clr();
    push(1, "br_nt_after", DEF, 2'b00, 2'b00, 2'b00, 1, 1);

    // forwarding priority and $0 suppression
    do_reset();
    cyc(); clr();
    ex_rs = 5; mem_rd = 5; wb_rd = 5;
    mem_reg_write = 1; wb_reg_write = 1;
    push(0, "fwd_mem", DEF, 2'b10, 2'b00, 2'b00, 0, 0);
    cyc(); mem_reg_write = 0;
    push(0, "fwd_wb", DEF, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc(); ex_rt = 5; mem_rd = 7; mem_reg_write = 1;
    push(0, "fwd_b_wb", DEF, 2'b01, 2'b01, 2'b00, 0, 0);
    cyc(); ex_rs = 7; ex_rt = 7;
    push(0, "fwd_ab_mem", DEF, 2'b10, 2'b10, 2'b00, 0, 0);
    cyc(); clr();
    mem_reg_write = 1; wb_reg_write = 1;
    push(0, "fwd_r0", DEF, 2'b00, 2'b00, 2'b00, 0, 0);

    // back-to-back stalls saturate a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(); lw_hazard();
      push(2, $sformatf("sat_%0d", i), STL, 2'b00, 2'b00,
           (i % 3 == 0) ? 2'b00 : 2'b01, (i > 15) ? 15 : i, 0);
    end
    // mid-STALL asynchronous reset, checked before the next edge
    cyc(); rst = 1'b1;
    push(2, "rst_mid_stall", DEF, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(); rst = 1'b0; clr();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end
endmodule
